// File: rtl/div3_share_arbiter.sv
// rtl/div3_share_arbiter.sv - round-robin share of one mod-3 evaluator (optional stats: DIV3_SHARE_STATS_EN)
module div3_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DIV3_SHARE_STATS_EN
    input  logic                     stat_clr,
    output logic [15:0]              stat_total,
    output logic [15:0]              stat_div3,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_div3,
    input  logic                     rsp_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   grant_next_ptr;
    logic [WIDTH-1:0] grant_data;
    logic             grant_div3;

    // Residue walk MSB first: r <- (2r + bit) mod 3; zero residue means divisible.
    function automatic logic is_div3(input logic [WIDTH-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            case ({r, v[i]})
                3'b000:  r = 2'd0;
                3'b001:  r = 2'd1;
                3'b010:  r = 2'd2;
                3'b011:  r = 2'd0;
                3'b100:  r = 2'd1;
                3'b101:  r = 2'd2;
                default: r = 2'd0;
            endcase
        end
        return (r == 2'd0);
    endfunction

    // Round-robin winner: first valid requester searching upward from rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_found    = 1'b0;
        grant_idx      = '0;
        grant_next_ptr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found    = 1'b1;
                grant_idx      = IDW'(idx);
                grant_next_ptr = IDW'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Operand mux for the winner and its verdict.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        grant_div3 = is_div3(grant_data);
    end

    // Accept is offered only in IDLE and never while reset is held; independent of rsp_ready.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (state == IDLE) && grant_found && (grant_idx == IDW'(i));
        end
    end

    // Control FSM with registered response channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_div3  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rsp_data  <= grant_data;
                        rsp_id    <= grant_idx;
                        rsp_div3  <= grant_div3;
                        rr_ptr    <= grant_next_ptr;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DIV3_SHARE_STATS_EN
    logic rsp_hs;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Saturating handshake counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= 16'd0;
            stat_div3  <= 16'd0;
        end else if (stat_clr) begin
            stat_total <= 16'd0;
            stat_div3  <= 16'd0;
        end else if (rsp_hs) begin
            if (stat_total != 16'hFFFF) begin
                stat_total <= stat_total + 16'd1;
            end
            if (rsp_div3 && (stat_div3 != 16'hFFFF)) begin
                stat_div3 <= stat_div3 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/div3_share_arbiter.md
# div3_share_arbiter

- Shares a single divisible-by-three evaluator among `NUM_REQ` requesters, each presenting a `WIDTH`-bit operand with a valid/ready handshake.
- Grants one requester at a time in round-robin order, registers the operand and its mod-3 verdict, and presents the result on one response channel tagged with the requester index.
- Sits between the operand producers and the divide-by-three check, so several producers can use one evaluator.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 4: operand width in bits, 2..16.
- `IDW`, `$clog2(NUM_REQ)`: requester index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_data` in `NUM_REQ*WIDTH`: packed operands; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `rsp_valid` out 1: response valid.
- `rsp_id` out `IDW`: index of the granted requester.
- `rsp_data` out `WIDTH`: echoed operand.
- `rsp_div3` out 1: 1 when `rsp_data` mod 3 == 0. Zero counts as divisible.
- `rsp_ready` in 1: downstream accepts the response.

## Operation
States:
- **IDLE**: `rsp_valid`=0.
  - If any `req_valid` is high, the round-robin winner g is the first set bit searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - `req_ready[g]`=1 combinationally; all other `req_ready` bits are 0.
  - On the edge: capture `req_data[g]` into `rsp_data`, g into `rsp_id`, and (operand mod 3 == 0) into `rsp_div3`.
  - Also on the edge: set `rr_ptr` to (g+1) mod `NUM_REQ` and go to RESP.
  - If no `req_valid` is high, all `req_ready`=0 and the block stays in IDLE.
- **RESP**: `rsp_valid`=1 and all `req_ready`=0.
  - `rsp_id`, `rsp_data` and `rsp_div3` hold stable until `rsp_valid && rsp_ready`.
  - On that edge, go to IDLE.

Rules:
- The mod-3 verdict is computed on the full `WIDTH`-bit unsigned operand. Any correct combinational residue logic is acceptable.
- `req_ready` depends on `req_valid`, `rr_ptr` and state only, never on `rsp_ready`.
- A requester that drops `req_valid` before its grant is simply skipped. No request is latched without a handshake.
- `rr_ptr` advances only on a grant. Idle cycles do not move it.
- `rr_ptr` reset value is 0. With all requests high and continuous `rsp_ready`, grant order is 0,1,...,`NUM_REQ`-1,0,...
- Reset mid-transaction discards the held response immediately. `rsp_valid` drops asynchronously.

Reset values:
- state IDLE, `rr_ptr`=0.
- `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_div3`=0.
- `req_ready`=0 while `rst_n`=0.

## Timing
- Grant edge N (`req_valid[g] && req_ready[g]`): `rsp_valid`=1 from cycle N+1.
- Response accept edge M (`rsp_valid && rsp_ready` at M): `rsp_valid`=0 in cycle M+1, and a new grant may occur in cycle M+1.
- Peak throughput is one operand per 2 cycles.
- `rsp_ready` held low stalls indefinitely. Outputs stay stable and no `req_ready` is asserted.
- Deassertion of `rst_n` takes effect at the first rising edge where `rst_n` is sampled high.

## Configuration
- Macro `DIV3_SHARE_STATS_EN`.
- **Defined**, the block adds:
  - input `stat_clr` (1 bit);
  - outputs `stat_total` (16 bits) and `stat_div3` (16 bits).
- `stat_total` increments on every response handshake. `stat_div3` increments on response handshakes with `rsp_div3`=1.
- Both counters saturate at 16'hFFFF and reset to 0.
- `stat_clr` synchronously zeroes both counters and takes priority over an increment in the same cycle.
- **Undefined**: these ports and counters do not exist, and the remaining behaviour is identical.

## Test plan
- **Reset:** `rst_n`=0 with all `req_valid`=1.
  - Required: `req_ready`=0, `rsp_valid`=0, `rsp_id`/`rsp_data`/`rsp_div3`=0.
  - After release, the first grant goes to requester 0.
- **Single request:** only requester 2 valid with data 12, `rsp_ready`=1.
  - Required: `req_ready`=4'b0100 in the grant cycle.
  - Next cycle: `rsp_valid`=1, `rsp_id`=2, `rsp_data`=12, `rsp_div3`=1.
  - Repeat with data 7: `rsp_div3`=0.
  - Repeat with data 0: `rsp_div3`=1.
- **Fairness:** all 4 requesters valid continuously with data 3, 1, 15, 14, `rsp_ready`=1.
  - Required `rsp_id` sequence: 0,1,2,3,0.
  - Required `rsp_div3` sequence: 1,0,1,0.
  - One response every 2 cycles.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after a response.
  - Required: outputs unchanged and `req_ready`=0 throughout.
  - Raising `rsp_ready` gives `rsp_valid`=0 the next cycle, then the next grant.
- **Reset mid-operation:** assert `rst_n`=0 while `rsp_valid`=1.
  - Required: `rsp_valid` falls without a clock edge.
  - After release, grant order restarts at 0.
- **Stats** (`DIV3_SHARE_STATS_EN` defined): 6 handshakes with operands 3,7,12,1,15,14.
  - Required: `stat_total`=6, `stat_div3`=3.
  - `stat_clr` pulsed in the same cycle as a handshake leaves both counters at 0 the next cycle.
